register_read_port: RTL and testbench

- Read-side companion to the bank of 8-bit load-enable registers.
- Accepts read requests (register index) on a valid/ready request channel.
- Snapshots the selected register's current value and presents it on a valid/ready response channel.
- Drives an output-enable for the shared CPU data bus and counts completed reads for debug.

---
 rtl/register_read_port.sv | 94 +++++++++
 tb/tb_register_read_port.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_read_port.sv
// Read-side port for the load-enable register bank: snapshots one
// register per request and returns it over a valid/ready response channel.
module register_read_port #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REGS*DATA_W-1:0] reg_bank,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       bus_oe,
  output logic [7:0]                 read_count
);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic [7:0]        r_count;
  logic [DATA_W-1:0] w_sel;
  logic              w_oor;
  logic              w_accept;
  logic              w_consume;

  assign rsp_valid  = (r_state == RESP);
  assign req_ready  = !rsp_valid | rsp_ready;
  assign w_accept   = req_valid & req_ready;
  assign w_consume  = rsp_valid & rsp_ready;
  assign bus_oe     = rsp_valid;
  assign rsp_data   = r_data;
  assign rsp_err    = r_err;
  assign read_count = r_count;

  // Full-width compare so no upper index aliases onto a real register.
  assign w_oor = 32'(req_addr) >= 32'(NUM_REGS);

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_W'(i)) begin
        w_sel = reg_bank[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (req_valid) w_next = RESP;
      RESP: if (rsp_ready && !req_valid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Snapshot taken only at acceptance; held through backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_data <= w_oor ? '0 : w_sel;
      r_err  <= w_oor;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (w_consume) begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_register_read_port.sv
// Scoreboard bench for register_read_port with a 6-entry bank so that
// indices 6 and 7 exercise the out-of-range path.
module tb_register_read_port;

  localparam int NR = 6;
  localparam int AW = 3;
  localparam int DW = 8;

  typedef struct {
    logic [7:0] d;
    logic       e;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR*DW-1:0]  reg_bank;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [AW-1:0]     req_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic              bus_oe;
  logic [7:0]        read_count;

  logic [7:0] regs [NR];
  exp_t       q [$];
  int         total = 0;
  int         bad = 0;
  int         exp_count = 0;

  register_read_port #(
    .NUM_REGS(NR),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_bank  (reg_bank),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .bus_oe    (bus_oe),
    .read_count(read_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) reg_bank[i*DW +: DW] = regs[i];
  end

  // Inputs only change 1ns after posedge, so negedge sees the values
  // the next posedge will act on.
  always @(negedge clk) begin
    exp_t x;
    if (!reset) begin
      if (rsp_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: rsp_data=%h with empty queue", rsp_data);
        end else if (rsp_data !== q[0].d || rsp_err !== q[0].e || bus_oe !== 1'b1) begin
          bad++;
          $display("FAIL sb_rsp: got d=%h e=%b oe=%b want d=%h e=%b oe=1",
                   rsp_data, rsp_err, bus_oe, q[0].d, q[0].e);
        end
        if (rsp_ready) begin
          if (q.size() != 0) x = q.pop_front();
          exp_count++;
        end
      end else begin
        total++;
        if (bus_oe !== 1'b0) begin
          bad++;
          $display("FAIL sb_oe_idle: bus_oe=%b want 0", bus_oe);
        end
      end
      if (req_valid && req_ready) begin
        if (int'(req_addr) < NR) begin
          x.d = regs[req_addr];
          x.e = 1'b0;
        end else begin
          x.d = 8'h00;
          x.e = 1'b1;
        end
        q.push_back(x);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    q.delete();
    exp_count = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_err !== 1'b0 ||
        read_count !== 8'd0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_vals: v=%b d=%h e=%b cnt=%0d rdy=%b want 0 00 0 0 1",
               rsp_valid, rsp_data, rsp_err, read_count, req_ready);
    end
    regs[2] = 8'h5A;
    req_addr = 3'd2;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A) begin
      bad++;
      $display("FAIL reset_pre: v=%b d=%h want 1 5a", rsp_valid, rsp_data);
    end
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || read_count !== 8'd0 ||
        bus_oe !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: v=%b d=%h cnt=%0d oe=%b want 0 00 0 0",
               rsp_valid, rsp_data, read_count, bus_oe);
    end
    q.delete();
    exp_count = 0;
    step();
    reset = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_rdy: req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_single();
    regs[3] = 8'hA5;
    req_addr = 3'd3;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL single_rsp: v=%b d=%h e=%b want 1 a5 0",
               rsp_valid, rsp_data, rsp_err);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0 || read_count !== 8'd1) begin
      bad++;
      $display("FAIL single_idle: v=%b cnt=%0d want 0 1", rsp_valid, read_count);
    end
  endtask

  task automatic test_backpressure();
    regs[1] = 8'h3C;
    req_addr = 3'd1;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    step();
    regs[1] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: v=%b d=%h rdy=%b want 1 3c 0",
                 i, rsp_valid, rsp_data, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_comb_rdy: req_ready=%b want 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF) begin
      bad++;
      $display("FAIL bp_next: v=%b d=%h want 1 ff", rsp_valid, rsp_data);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int base;
    logic [7:0] want;
    for (int i = 0; i < NR; i++) regs[i] = 8'h10 + 8'(i);
    base = exp_count;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = AW'(i);
      step();
      want = (i < NR) ? 8'h10 + 8'(i) : 8'h00;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== want || rsp_err !== (i >= NR)) begin
        bad++;
        $display("FAIL b2b[%0d]: v=%b d=%h e=%b want 1 %h %b",
                 i, rsp_valid, rsp_data, rsp_err, want, i >= NR);
      end
    end
    req_valid = 1'b0;
    step();
    total++;
    if (rsp_valid !== 1'b0 || read_count !== 8'(base + 8)) begin
      bad++;
      $display("FAIL b2b_count: v=%b cnt=%0d want 0 %0d",
               rsp_valid, read_count, (base + 8) % 256);
    end
  endtask

  task automatic test_out_of_range();
    regs[5] = 8'h77;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = 3'd7;
    step();
    total++;
    if (rsp_data !== 8'h00 || rsp_err !== 1'b1) begin
      bad++;
      $display("FAIL oor_7: d=%h e=%b want 00 1", rsp_data, rsp_err);
    end
    req_addr = 3'd5;
    step();
    req_valid = 1'b0;
    total++;
    if (rsp_data !== 8'h77 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL oor_5: d=%h e=%b want 77 0", rsp_data, rsp_err);
    end
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      req_addr = AW'($urandom_range(0, 7));
      regs[$urandom_range(0, NR - 1)] = 8'($urandom);
      step();
    end
    req_valid = 1'b0;
    step();
    total++;
    if (read_count !== 8'd0 || exp_count != 256) begin
      bad++;
      $display("FAIL wrap_256: cnt=%0d model=%0d want 0 256", read_count, exp_count);
    end
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    total++;
    if (read_count !== 8'd1) begin
      bad++;
      $display("FAIL wrap_257: cnt=%0d want 1", read_count);
    end
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_addr = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) regs[$urandom_range(0, NR - 1)] = 8'($urandom);
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (rsp_valid && n < 10) begin
      step();
      n++;
    end
    step();
    total++;
    if (rsp_valid !== 1'b0 || q.size() != 0 || read_count !== 8'(exp_count)) begin
      bad++;
      $display("FAIL rand_drain: v=%b qsize=%0d cnt=%0d want 0 0 %0d",
               rsp_valid, q.size(), read_count, exp_count % 256);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = 8'h00;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
